wdg_kicker: RTL and testbench
=============================

WDG_KICKER -- requirements
Module: wdg_kicker

Interface
REQ-001 Parameter HALF_PERIOD, default 28'd50_000_000, cycles between consecutive pulso strobes; legal range 2..2^28-1; must be below the monitoring watchdog's timeout.
REQ-002 Parameter STALL_MAX, default 28'd100_000_000, cycles of held-off kicking before stalled asserts.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-005 enable  input  1  1 = generate kick sequence; 0 = idle.
REQ-006 alive  input  1  application health; 1 = kicking permitted.
REQ-007 error  input  1  timeout indication from the monitoring watchdog.
REQ-008 wdg  output  1  heartbeat level presented to the watchdog.
REQ-009 pulso  output  1  one-cycle strobe qualifying wdg.
REQ-010 kick_done  output  1  one-cycle strobe when a full high/low kick pair completes.
REQ-011 stalled  output  1  level; alive held off kicking for at least STALL_MAX cycles.
REQ-012 trip_count  output  8  count of error events since reset, saturating.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states SHALL be IDLE, PULSE_HI, WAIT_HI, PULSE_LO, WAIT_LO.
- IDLE -> PULSE_HI when enable=1.
- PULSE_HI -> WAIT_HI.
- WAIT_HI -> PULSE_LO when timer expired and alive=1.
- PULSE_LO -> WAIT_LO.
- WAIT_LO -> PULSE_HI when timer expired and alive=1.
REQ-015 In the PULSE_HI cycle, outputs SHALL be wdg=1 and pulso=1; in the PULSE_LO cycle, wdg=0 and pulso=1; wdg SHALL hold its last value in the WAIT states; pulso=0 in every other state.
REQ-016 Timing with alive=1 continuously: pulso rising edges SHALL be exactly HALF_PERIOD cycles apart; first pulso SHALL occur 1 cycle after enable is sampled high in IDLE.
REQ-017 Timer: 28-bit, cleared on entry to each WAIT state; "expired" means count == HALF_PERIOD-2; the timer holds at expiry and never wraps.
REQ-018 Alive gating: while expired and alive=0, the FSM SHALL stay in its WAIT state. The 28-bit stall counter SHALL increment each such cycle, saturating, and clear when a PULSE state is entered.
REQ-019 stalled SHALL be 1 while stall counter >= STALL_MAX; it clears in the cycle after the next pulso.
REQ-020 kick_done SHALL pulse in the same cycle as the pulso of PULSE_LO.
REQ-021 error=1 sampled in any non-IDLE state:
- trip_count increments, saturating at 8'd255.
- Next state is PULSE_HI; timer and stall counter clear.
REQ-022 Consecutive error cycles SHALL each count, and each restarts the sequence.
REQ-023 error=1 in IDLE SHALL increment trip_count only; no state change.
REQ-024 enable=0 in any state SHALL force next state IDLE with wdg=0 and pulso=0. This has priority over error restart; a simultaneous error is still counted.
REQ-025 Deasserting enable during a PULSE cycle SHALL NOT extend pulso beyond that cycle.

Reset
REQ-026 reset=0 at posedge clk SHALL produce, from the next cycle:
- state IDLE
- wdg=0, pulso=0, kick_done=0, stalled=0, trip_count=0
- timer=0, stall counter=0
REQ-027 Reset SHALL override all inputs, including mid-WAIT and mid-PULSE.

Configuration
REQ-028 Macro WDG_KICKER_FAULT_INJ_EN.
- Defined: adds input inject_fault (1 bit). While inject_fault=1, PULSE_HI/PULSE_LO entry is blocked exactly as for alive=0, including stall counting. This deliberately starves the watchdog.
- Undefined: the port is absent and behaviour is as REQ-013..025.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding (3-bit localparams), the 28-bit timer width constant, and the default HALF_PERIOD/STALL_MAX values.
REQ-030 One sub-module, wdg_sat_counter (parameterised width, inc/clr, saturating), SHALL be used for the timer, the stall counter and trip_count.

Verification (HALF_PERIOD=8, STALL_MAX=20 in bench)
REQ-031 Reset low 3 cycles, then enable=1, alive=1 -> first pulso with wdg=1 one cycle after enable is sampled; next pulso with wdg=0 exactly 8 cycles later, with kick_done=1 in that cycle.
REQ-032 alive=0 from cycle 5 of WAIT_HI for 30 cycles -> no pulso, stalled=1 after 20 held-off cycles; alive=1 -> PULSE_LO next cycle; stalled clears one cycle later.
REQ-033 error=1 for 1 cycle in WAIT_LO -> trip_count=1, PULSE_HI (wdg=1, pulso=1) next cycle; 300 error pulses -> trip_count=255.
REQ-034 enable=0 and error=1 in the same cycle in WAIT_HI -> IDLE, wdg=0, trip_count increments.
REQ-035 reset=0 during PULSE_LO -> all outputs 0 the next cycle; kick_done not asserted afterwards.
REQ-036 With WDG_KICKER_FAULT_INJ_EN defined: inject_fault=1 for 25 cycles -> no pulso, stalled=1; release -> kicking resumes within 1 cycle.

Source files
------------

// File: rtl/wdg_kicker_pkg.sv
// Shared definitions for the watchdog kicker: state encoding, timer width and
// default timing parameters.
package wdg_kicker_pkg;

    localparam int TMR_W = 28;

    localparam logic [TMR_W-1:0] DEF_HALF_PERIOD = 28'd50_000_000;
    localparam logic [TMR_W-1:0] DEF_STALL_MAX   = 28'd100_000_000;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PULSE_HI = 3'd1;
    localparam logic [2:0] ST_WAIT_HI  = 3'd2;
    localparam logic [2:0] ST_PULSE_LO = 3'd3;
    localparam logic [2:0] ST_WAIT_LO  = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PULSE_HI = ST_PULSE_HI,
        WAIT_HI  = ST_WAIT_HI,
        PULSE_LO = ST_PULSE_LO,
        WAIT_LO  = ST_WAIT_LO
    } state_t;

    function automatic logic is_pulse(input state_t s);
        return (s == PULSE_HI) || (s == PULSE_LO);
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == WAIT_HI) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/wdg_kicker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module wdg_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wdg_kicker.sv
// Watchdog kicker: toggles a heartbeat level with qualifying strobes, gated by
// application health. Optional macro WDG_KICKER_FAULT_INJ_EN adds inject_fault.
module wdg_kicker
    import wdg_kicker_pkg::*;
#(
    parameter logic [TMR_W-1:0] HALF_PERIOD = DEF_HALF_PERIOD,
    parameter logic [TMR_W-1:0] STALL_MAX   = DEF_STALL_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       alive,
    input  logic       error,
`ifdef WDG_KICKER_FAULT_INJ_EN
    input  logic       inject_fault,
`endif
    output logic       wdg,
    output logic       pulso,
    output logic       kick_done,
    output logic       stalled,
    output logic [7:0] trip_count
);

    state_t state_q;
    state_t state_d;
    state_t fsm_next_s;

    logic wdg_q;
    logic wdg_d;
    logic pulso_q;
    logic pulso_d;
    logic kick_done_q;
    logic kick_done_d;
    logic stalled_q;
    logic stalled_d;

    logic [TMR_W-1:0] timer_s;
    logic [TMR_W-1:0] stall_cnt_s;
    logic [7:0]       trip_cnt_s;

    logic permit_s;
    logic expired_s;
    logic timer_clr_s;
    logic timer_inc_s;
    logic stall_clr_s;
    logic stall_inc_s;

    // Kicking permission: health, optionally vetoed by deliberate fault injection.
    always_comb begin
`ifdef WDG_KICKER_FAULT_INJ_EN
        permit_s = alive && !inject_fault;
`else
        permit_s = alive;
`endif
    end

    assign expired_s = (timer_s == (HALF_PERIOD - 28'd2));

    // Sequence transitions, then enable/error overrides (enable has priority).
    always_comb begin
        fsm_next_s = state_q;
        case (state_q)
            IDLE:     fsm_next_s = enable ? PULSE_HI : IDLE;
            PULSE_HI: fsm_next_s = WAIT_HI;
            WAIT_HI:  fsm_next_s = (expired_s && permit_s) ? PULSE_LO : WAIT_HI;
            PULSE_LO: fsm_next_s = WAIT_LO;
            WAIT_LO:  fsm_next_s = (expired_s && permit_s) ? PULSE_HI : WAIT_LO;
            default:  fsm_next_s = IDLE;
        endcase

        state_d = fsm_next_s;
        if (!enable) begin
            state_d = IDLE;
        end else if (error && (state_q != IDLE)) begin
            state_d = PULSE_HI;
        end else begin
            state_d = fsm_next_s;
        end
    end

    // Counter controls; the timer restarts whenever a WAIT state is (re)entered.
    always_comb begin
        timer_clr_s = !is_wait(state_q) || (state_d != state_q);
        timer_inc_s = is_wait(state_q) && !expired_s;
        stall_clr_s = is_pulse(state_d) || (state_d == IDLE);
        stall_inc_s = is_wait(state_q) && expired_s && !permit_s && (state_d == state_q);
    end

    // Output values for the cycle the next state is occupied.
    always_comb begin
        wdg_d       = 1'b0;
        pulso_d     = 1'b0;
        kick_done_d = 1'b0;
        stalled_d   = (stall_cnt_s >= STALL_MAX);
        case (state_d)
            PULSE_HI: begin
                wdg_d   = 1'b1;
                pulso_d = 1'b1;
            end
            PULSE_LO: begin
                wdg_d       = 1'b0;
                pulso_d     = 1'b1;
                kick_done_d = 1'b1;
            end
            WAIT_HI, WAIT_LO: wdg_d = wdg_q;
            default:          wdg_d = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wdg_q       <= 1'b0;
            pulso_q     <= 1'b0;
            kick_done_q <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdg_q       <= wdg_d;
            pulso_q     <= pulso_d;
            kick_done_q <= kick_done_d;
            stalled_q   <= stalled_d;
        end
    end

    wdg_sat_counter #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr_s),
        .inc   (timer_inc_s),
        .count (timer_s)
    );

    wdg_sat_counter #(.W(TMR_W)) u_stall (
        .clk   (clk),
        .reset (reset),
        .clr   (stall_clr_s),
        .inc   (stall_inc_s),
        .count (stall_cnt_s)
    );

    // Every sampled error counts, including in IDLE and alongside enable=0.
    wdg_sat_counter #(.W(8)) u_trip (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (error),
        .count (trip_cnt_s)
    );

    assign wdg        = wdg_q;
    assign pulso      = pulso_q;
    assign kick_done  = kick_done_q;
    assign stalled    = stalled_q;
    assign trip_count = trip_cnt_s;

endmodule

// File: tb/tb_wdg_kicker.sv
// Scoreboard bench for wdg_kicker with HALF_PERIOD=8, STALL_MAX=20; expected
// strobes are queued with their cycle stamp and checked by a separate monitor.
module tb_wdg_kicker;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       alive;
    logic       error;
    logic       inject_fault;
    logic       wdg;
    logic       pulso;
    logic       kick_done;
    logic       stalled;
    logic [7:0] trip_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        logic       wdg;
        logic       kd;
        logic [7:0] trip;
        logic       st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    wdg_kicker #(.HALF_PERIOD(28'd8), .STALL_MAX(28'd20)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .alive      (alive),
        .error      (error),
`ifdef WDG_KICKER_FAULT_INJ_EN
        .inject_fault (inject_fault),
`endif
        .wdg        (wdg),
        .pulso      (pulso),
        .kick_done  (kick_done),
        .stalled    (stalled),
        .trip_count (trip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic w, input logic kd,
                        input logic [7:0] trip, input logic st);
        exp_t e;
        e.at = at; e.wdg = w; e.kd = kd; e.trip = trip; e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulso expected at cycle %0d, now %0d", exp_q[0].at, cyc);
            void'(exp_q.pop_front());
        end
        if (pulso === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulso at cycle %0d wdg=%0b kd=%0b", cyc, wdg, kick_done);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.at != cyc || wdg !== mon_e.wdg || kick_done !== mon_e.kd ||
                    trip_count !== mon_e.trip || stalled !== mon_e.st) begin
                    errors++;
                    $display("FAIL pulso_fields got cyc=%0d wdg=%0b kd=%0b trip=%0d st=%0b expected cyc=%0d wdg=%0b kd=%0b trip=%0d st=%0b",
                             cyc, wdg, kick_done, trip_count, stalled,
                             mon_e.at, mon_e.wdg, mon_e.kd, mon_e.trip, mon_e.st);
                end
            end
        end else if (kick_done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL kick_done_without_pulso at cycle %0d got %0b expected 0", cyc, kick_done);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        int e;
        int p;
        int r;
        int s;
        reset = 1'b0; enable = 1'b0; alive = 1'b1; error = 1'b0; inject_fault = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_wdg", {31'd0, wdg}, 32'd0);
        chk("reset_pulso", {31'd0, pulso}, 32'd0);
        chk("reset_kick_done", {31'd0, kick_done}, 32'd0);
        chk("reset_stalled", {31'd0, stalled}, 32'd0);
        chk("reset_trip", {24'd0, trip_count}, 32'd0);

        // Free-running kicks, then alive held off from WAIT_HI cycle 5.
        e = cyc;
        push(e + 1, 1'b1, 1'b0, 8'd0, 1'b0);
        push(e + 9, 1'b0, 1'b1, 8'd0, 1'b0);
        push(e + 17, 1'b1, 1'b0, 8'd0, 1'b0);
        push(e + 53, 1'b0, 1'b1, 8'd0, 1'b1);
        reset = 1'b1; enable = 1'b1;

        wait_until(e + 22);
        alive = 1'b0;
        wait_until(e + 30);
        chk("wait_hi_holds_wdg", {31'd0, wdg}, 32'd1);
        wait_until(e + 44);
        chk("stalled_before_limit", {31'd0, stalled}, 32'd0);
        wait_until(e + 45);
        chk("stalled_at_limit", {31'd0, stalled}, 32'd1);
        wait_until(e + 52);
        alive = 1'b1;
        wait_until(e + 54);
        chk("stalled_cleared", {31'd0, stalled}, 32'd0);

        // Single error in WAIT_LO restarts at PULSE_HI.
        p = e + 53;
        push(p + 4, 1'b1, 1'b0, 8'd1, 1'b0);
        wait_until(p + 3);
        error = 1'b1;
        wait_until(p + 4);
        error = 1'b0;

        // enable=0 with error in WAIT_HI: IDLE wins, error still counted.
        wait_until(p + 6);
        enable = 1'b0; error = 1'b1;
        wait_until(p + 7);
        error = 1'b0;
        chk("disable_err_wdg", {31'd0, wdg}, 32'd0);
        chk("disable_err_trip", {24'd0, trip_count}, 32'd2);
        wait_until(p + 8);
        error = 1'b1;
        wait_until(p + 9);
        error = 1'b0;
        chk("idle_err_trip", {24'd0, trip_count}, 32'd3);
        chk("idle_err_pulso", {31'd0, pulso}, 32'd0);

        // 300 consecutive errors: one restart strobe each, trip saturates.
        r = p + 10;
        push(r + 1, 1'b1, 1'b0, 8'd3, 1'b0);
        for (int i = 0; i < 300; i++) begin
            push(r + 4 + i, 1'b1, 1'b0, (4 + i > 255) ? 8'd255 : 8'(4 + i), 1'b0);
        end
        push(r + 311, 1'b0, 1'b1, 8'd255, 1'b0);
        wait_until(r);
        enable = 1'b1;
        wait_until(r + 3);
        error = 1'b1;
        wait_until(r + 303);
        error = 1'b0;
        chk("trip_saturated", {24'd0, trip_count}, 32'd255);

        // Reset asserted during PULSE_LO.
        wait_until(r + 311);
        reset = 1'b0; enable = 1'b0;
        wait_until(r + 312);
        reset = 1'b1;
        chk("midreset_wdg", {31'd0, wdg}, 32'd0);
        chk("midreset_pulso", {31'd0, pulso}, 32'd0);
        chk("midreset_kick_done", {31'd0, kick_done}, 32'd0);
        chk("midreset_stalled", {31'd0, stalled}, 32'd0);
        chk("midreset_trip", {24'd0, trip_count}, 32'd0);
        wait_until(r + 332);

`ifdef WDG_KICKER_FAULT_INJ_EN
        // Fault injection starves the watchdog until released.
        s = cyc;
        push(s + 1, 1'b1, 1'b0, 8'd0, 1'b0);
        push(s + 34, 1'b0, 1'b1, 8'd0, 1'b1);
        enable = 1'b1;
        wait_until(s + 8);
        inject_fault = 1'b1;
        wait_until(s + 32);
        chk("inject_stalled", {31'd0, stalled}, 32'd1);
        wait_until(s + 33);
        inject_fault = 1'b0;
        wait_until(s + 34);
        enable = 1'b0;
        wait_until(s + 40);
`else
        s = cyc;
        wait_until(s + 2);
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
